rr_req_fifo_bank: RTL and testbench

- Requester-side companion stage to the 4-way time-sliced round-robin arbiter.
- Holds one small FIFO per requester and drives the arbiter's REQ vector from FIFO occupancy.
- Consumes the arbiter's registered GNT vector and pops the granted FIFO once per granted cycle.
- Presents the popped word on a single shared output bus, tagged with its source index.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_req_fifo_bank_if.sv | 12 +
 rtl/rr_sync_fifo.sv | 38 +++
 rtl/rr_req_fifo_bank.sv | 53 +++++
 tb/tb_rr_req_fifo_bank.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared requester count, source-index width and grant-vector helpers
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int SRC_W = 2;
   function automatic logic is_onehot(input logic [N_REQ-1:0] v);
      return (v != '0) && ((v & (v - N_REQ'(1))) == '0);
   endfunction
   function automatic logic [SRC_W-1:0] onehot_idx(input logic [N_REQ-1:0] v);
      logic [SRC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) if (v[i]) idx = SRC_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/rr_req_fifo_bank_if.sv
// rr_req_fifo_bank_if: push side, arbiter req/gnt and shared output bus of the fifo bank
interface rr_req_fifo_bank_if #(parameter int DATA_W = 8);
   logic [arb_pkg::N_REQ-1:0] push_valid, push_ready, REQ, GNT;
   logic [arb_pkg::N_REQ*DATA_W-1:0] push_data;
   logic out_valid, stale_gnt, gnt_err;
   logic [DATA_W-1:0] out_data;
   logic [arb_pkg::SRC_W-1:0] out_src;
   modport master(output push_valid, push_data, GNT,
                  input push_ready, REQ, out_valid, out_data, out_src, stale_gnt, gnt_err);
   modport slave(input push_valid, push_data, GNT,
                 output push_ready, REQ, out_valid, out_data, out_src, stale_gnt, gnt_err);
endinterface

// File: rtl/rr_sync_fifo.sv
// rr_sync_fifo: single-clock fifo; push ignored when full, pop ignored when empty
module rr_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic full,
   output logic empty
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0] occ;
   logic wr, rd;
   assign full = occ == (PTR_W+1)'(DEPTH);
   assign empty = occ == '0;
   assign wr = push & ~full;
   assign rd = pop & ~empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(wr);
         rd_ptr <= rd_ptr + PTR_W'(rd);
         occ <= occ + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);
      end
   // contents are don't-care after reset; only pointers define validity
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/rr_req_fifo_bank.sv
// rr_req_fifo_bank: per-requester fifos feeding the round-robin arbiter, popping on its grant
module rr_req_fifo_bank
   import arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   rr_req_fifo_bank_if.slave bus
);
   logic [DATA_W-1:0] head [N_REQ];
   logic [N_REQ-1:0] full, empty, pop;
   logic gnt_ok;
   logic [SRC_W-1:0] sel;
   assign gnt_ok = is_onehot(bus.GNT);
   assign sel = onehot_idx(bus.GNT);
   assign pop = gnt_ok ? bus.GNT & ~empty : '0;
   assign bus.push_ready = ~full;
   assign bus.REQ = ~empty;
   genvar i;
   generate
      for (i = 0; i < N_REQ; i++) begin : g_fifo
         rr_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(bus.push_valid[i]),
            .pop(pop[i]),
            .din(bus.push_data[i*DATA_W +: DATA_W]),
            .dout(head[i]),
            .full(full[i]),
            .empty(empty[i])
         );
      end
   endgenerate
   // a one-hot grant that pops nothing hit an empty fifo: expected arbiter lag, not an error
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_src <= '0;
         bus.stale_gnt <= 1'b0;
         bus.gnt_err <= 1'b0;
      end else begin
         bus.out_valid <= |pop;
         if (|pop) begin
            bus.out_data <= head[sel];
            bus.out_src <= sel;
         end
         bus.stale_gnt <= gnt_ok && pop == '0;
         bus.gnt_err <= bus.gnt_err | (bus.GNT != '0 && !gnt_ok);
      end
endmodule

// File: tb/tb_rr_req_fifo_bank.sv
// tb_rr_req_fifo_bank: directed checks of push/pop, full, stale grant, grant error and a sliced grant loop
module tb_rr_req_fifo_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   int nxt [4];
   rr_req_fifo_bank_if #(.DATA_W(8)) bus();
   rr_req_fifo_bank #(.DATA_W(8), .DEPTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push1(input int i, input logic [7:0] d);
      bus.push_valid[i] = 1'b1;
      bus.push_data[i*8 +: 8] = d;
      tick();
      bus.push_valid[i] = 1'b0;
   endtask
   initial begin
      bus.push_valid = '0;
      bus.push_data = '0;
      bus.GNT = '0;
      tick();
      tick();
      check("rst_req", bus.REQ, 4'b0000);
      check("rst_ready", bus.push_ready, 4'b1111);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_src", bus.out_src, 0);
      check("rst_stale", bus.stale_gnt, 0);
      check("rst_err", bus.gnt_err, 0);
      rst = 1'b0;
      // prefilled fifo 2 must be wiped by an asynchronous reset
      push1(2, 8'h21);
      push1(2, 8'h22);
      push1(2, 8'h23);
      check("pre_req", bus.REQ, 4'b0100);
      rst = 1'b1;
      #1;
      check("arst_req", bus.REQ, 4'b0000);
      check("arst_ready", bus.push_ready, 4'b1111);
      check("arst_valid", bus.out_valid, 0);
      tick();
      rst = 1'b0;
      bus.GNT = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("arst_nopop", bus.out_valid, 0);
         check("arst_stale", bus.stale_gnt, 1);
      end
      bus.GNT = '0;
      tick();
      // two words through fifo 0, then a stale grant
      push1(0, 8'hA1);
      push1(0, 8'hA2);
      check("f0_req", bus.REQ, 4'b0001);
      bus.GNT = 4'b0001;
      tick();
      check("f0_v1", bus.out_valid, 1);
      check("f0_d1", bus.out_data, 8'hA1);
      check("f0_s1", bus.out_src, 0);
      check("f0_req1", bus.REQ, 4'b0001);
      tick();
      check("f0_v2", bus.out_valid, 1);
      check("f0_d2", bus.out_data, 8'hA2);
      check("f0_req2", bus.REQ, 4'b0000);
      tick();
      check("f0_v3", bus.out_valid, 0);
      check("f0_stale", bus.stale_gnt, 1);
      bus.GNT = '0;
      tick();
      check("f0_stale_clr", bus.stale_gnt, 0);
      check("f0_hold", bus.out_data, 8'hA2);
      // fill fifo 3; pushes while full are dropped, even alongside a pop
      for (int k = 1; k <= 4; k++) push1(3, 8'(8'h30 + k));
      check("f3_full", bus.push_ready, 4'b0111);
      push1(3, 8'h35);
      check("f3_full2", bus.push_ready, 4'b0111);
      bus.push_valid[3] = 1'b1;
      bus.push_data[31:24] = 8'h36;
      bus.GNT = 4'b1000;
      tick();
      bus.push_valid[3] = 1'b0;
      check("f3_pop_d", bus.out_data, 8'h31);
      check("f3_ready", bus.push_ready, 4'b1111);
      for (int k = 2; k <= 4; k++) begin
         tick();
         check("f3_seq", bus.out_data, 8'h30 + k);
         check("f3_src", bus.out_src, 3);
      end
      tick();
      check("f3_empty", bus.out_valid, 0);
      check("f3_stale", bus.stale_gnt, 1);
      bus.GNT = '0;
      tick();
      // streaming through fifo 1 across several pointer wraps
      push1(1, 8'h40);
      bus.GNT = 4'b0010;
      for (int k = 1; k <= 12; k++) begin
         bus.push_valid[1] = 1'b1;
         bus.push_data[15:8] = 8'(8'h40 + k);
         tick();
         check("f1_stream", bus.out_data, 8'h40 + k - 1);
         check("f1_valid", bus.out_valid, 1);
         check("f1_src", bus.out_src, 1);
         check("f1_req", bus.REQ, 4'b0010);
      end
      bus.push_valid[1] = 1'b0;
      tick();
      check("f1_last", bus.out_data, 8'h4C);
      tick();
      check("f1_stale", bus.stale_gnt, 1);
      bus.GNT = '0;
      tick();
      // multi-hot grant: no pop, sticky error
      bus.push_valid = 4'b0101;
      bus.push_data[7:0] = 8'h01;
      bus.push_data[23:16] = 8'h02;
      tick();
      bus.push_valid = '0;
      bus.GNT = 4'b0101;
      tick();
      check("mh_valid", bus.out_valid, 0);
      check("mh_err", bus.gnt_err, 1);
      check("mh_stale", bus.stale_gnt, 0);
      check("mh_req", bus.REQ, 4'b0101);
      bus.GNT = '0;
      tick();
      check("mh_sticky", bus.gnt_err, 1);
      bus.GNT = 4'b0100;
      tick();
      check("mh_d2", bus.out_data, 8'h02);
      check("mh_s2", bus.out_src, 2);
      bus.GNT = 4'b0001;
      tick();
      check("mh_d0", bus.out_data, 8'h01);
      check("mh_s0", bus.out_src, 0);
      bus.GNT = '0;
      tick();
      check("mh_sticky2", bus.gnt_err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mh_rst", bus.gnt_err, 0);
      // time-sliced grant loop: 3-cycle slices per source, two rounds
      bus.push_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         for (int s = 0; s < 4; s++) bus.push_data[s*8 +: 8] = 8'(s*16 + k);
         tick();
      end
      bus.push_valid = '0;
      check("cl_req", bus.REQ, 4'b1111);
      for (int s = 0; s < 4; s++) nxt[s] = 0;
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < 3; c++) begin
               bus.GNT = 4'(1 << s);
               tick();
               check("cl_valid", bus.out_valid, (r == 0 || c == 0) ? 1 : 0);
               check("cl_stale", bus.stale_gnt, (r == 0 || c == 0) ? 0 : 1);
               if (bus.out_valid) begin
                  check("cl_data", bus.out_data, s*16 + nxt[s]);
                  check("cl_src", bus.out_src, s);
                  nxt[s]++;
               end
            end
      bus.GNT = '0;
      tick();
      for (int s = 0; s < 4; s++) check("cl_count", nxt[s], 4);
      check("cl_drained", bus.REQ, 4'b0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
